// File: rtl/color_fill_pkg.sv
// Shared types and screen geometry for the wireframe-to-framebuffer colour fill.
package color_fill_pkg;

  localparam int DEF_SCREEN_W = 320;
  localparam int DEF_SCREEN_H = 240;

  localparam int X_W = $clog2(DEF_SCREEN_W);
  localparam int Y_W = $clog2(DEF_SCREEN_H);

  localparam int WIREFRAME_ADDR_SIZE = $clog2(DEF_SCREEN_W * DEF_SCREEN_H);
  localparam int FB_ADDR_SIZE        = WIREFRAME_ADDR_SIZE;

  localparam int COLOR_W = 16;
  typedef logic [COLOR_W-1:0] Color;

  // x fields are wide enough to carry an out-of-range value (e.g. 320) so it can be rejected
  typedef struct packed {
    logic [X_W-1:0] x_min;
    logic [X_W-1:0] x_max;
    logic [Y_W-1:0] y_min;
    logic [Y_W-1:0] y_max;
  } BBox;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_SCAN_DRAIN,
    ST_FILL,
    ST_NEXT_ROW,
    ST_DONE
  } fill_state_t;

endpackage

// File: rtl/color_fill_if.sv
// Command, wireframe SRAM and frame buffer signals of the colour fill block.
// master = requester/memory side, slave = color_fill.
interface color_fill_if;
  import color_fill_pkg::*;

  logic                           start;
  BBox                            i_bbox;
  Color                           i_color;
  logic [WIREFRAME_ADDR_SIZE-1:0] wf_addr;
  logic                           wf_rdata;
  logic                           wf_we;
  logic                           wf_wdata;
  logic [FB_ADDR_SIZE-1:0]        fb_addr;
  Color                           fb_data;
  logic                           fb_wr;
  logic                           fb_ready;
  logic                           busy;
  logic                           done;

  modport master (
    output start, i_bbox, i_color, wf_rdata, fb_ready,
    input  wf_addr, wf_we, wf_wdata, fb_addr, fb_data, fb_wr, busy, done
  );

  modport slave (
    input  start, i_bbox, i_color, wf_rdata, fb_ready,
    output wf_addr, wf_we, wf_wdata, fb_addr, fb_data, fb_wr, busy, done
  );

endinterface

// File: rtl/color_fill_span_finder.sv
// Tracks the leftmost/rightmost set wireframe pixel of the row being scanned.
// Read data arrives one cycle after its address, so the issuing x and valid are
// delayed by one stage to line up with the data. hit/left also include the sample
// arriving this cycle so the controller can decide on the row without an extra cycle.
module color_fill_span_finder
  import color_fill_pkg::*;
(
  input  logic           clk,
  input  logic           n_rst,
  input  logic           clr,
  input  logic           vld,
  input  logic [X_W-1:0] x,
  input  logic           data,
  output logic [X_W-1:0] left,
  output logic [X_W-1:0] right,
  output logic           hit
);

  logic [X_W-1:0] x_p1;
  logic           vld_p1;
  logic [X_W-1:0] left_q;
  logic [X_W-1:0] right_q;
  logic           hit_q;
  logic           sample_hit;

  assign sample_hit = vld_p1 & data;

  // Align x with returning read data and record first/last set pixel of the row
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      x_p1    <= '0;
      vld_p1  <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      x_p1   <= x;
      vld_p1 <= vld;
      if (clr) begin
        left_q  <= '0;
        right_q <= '0;
        hit_q   <= 1'b0;
      end else if (sample_hit) begin
        if (!hit_q) left_q <= x_p1;
        right_q <= x_p1;
        hit_q   <= 1'b1;
      end
    end
  end

  assign hit   = hit_q | sample_hit;
  assign left  = hit_q ? left_q : x_p1;
  assign right = right_q;

endmodule

// File: rtl/color_fill.sv
// Scans the wireframe inside the bounding box row by row and writes the fill
// colour between the outermost edge pixels of each row.
// Optional feature macro CLEAR_WF_EN: every accepted frame buffer write also
// clears the same wireframe pixel, leaving a clean wireframe for the next triangle.
module color_fill
  import color_fill_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic        clk,
  input  logic        n_rst,
  color_fill_if.slave bus
);

  typedef logic [WIREFRAME_ADDR_SIZE-1:0] addr_t;

  fill_state_t    state;
  logic [X_W-1:0] x_min_q;
  logic [X_W-1:0] x_max_q;
  logic [Y_W-1:0] y_max_q;
  Color           color_q;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  addr_t          wf_addr_q;
  logic [FB_ADDR_SIZE-1:0] fb_addr_q;
  Color           fb_data_q;
  logic           fb_wr_q;
  logic           busy_q;
  logic           done_q;

  logic           fb_accept;
  logic           bbox_bad;
  logic [X_W-1:0] span_left;
  logic [X_W-1:0] span_right;
  logic           span_hit;

  function automatic addr_t pix_addr(input logic [Y_W-1:0] py, input logic [X_W-1:0] px);
    return addr_t'(py) * addr_t'(SCREEN_W) + addr_t'(px);
  endfunction

  assign fb_accept = fb_wr_q & bus.fb_ready;

  assign bbox_bad = (bus.i_bbox.x_min > bus.i_bbox.x_max) ||
                    (bus.i_bbox.y_min > bus.i_bbox.y_max) ||
                    (int'(bus.i_bbox.x_max) >= SCREEN_W)  ||
                    (int'(bus.i_bbox.y_max) >= SCREEN_H);

  color_fill_span_finder u_span (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   ((state == ST_IDLE) || (state == ST_NEXT_ROW)),
    .vld   (state == ST_SCAN),
    .x     (x),
    .data  (bus.wf_rdata),
    .left  (span_left),
    .right (span_right),
    .hit   (span_hit)
  );

  // Control FSM with registered address, write and status outputs
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= ST_IDLE;
      x_min_q   <= '0;
      x_max_q   <= '0;
      y_max_q   <= '0;
      color_q   <= '0;
      x         <= '0;
      y         <= '0;
      wf_addr_q <= '0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
      fb_wr_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            x_min_q <= bus.i_bbox.x_min;
            x_max_q <= bus.i_bbox.x_max;
            y_max_q <= bus.i_bbox.y_max;
            color_q <= bus.i_color;
            y       <= bus.i_bbox.y_min;
            busy_q  <= 1'b1;
            if (bbox_bad) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              x         <= bus.i_bbox.x_min;
              wf_addr_q <= pix_addr(bus.i_bbox.y_min, bus.i_bbox.x_min);
              state     <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (x == x_max_q) begin
            state <= ST_SCAN_DRAIN;
          end else begin
            x         <= x + 1'b1;
            wf_addr_q <= wf_addr_q + 1'b1;
          end
        end
        ST_SCAN_DRAIN: begin
          if (span_hit) begin
            x         <= span_left;
            fb_addr_q <= pix_addr(y, span_left);
            wf_addr_q <= pix_addr(y, span_left);
            fb_data_q <= color_q;
            fb_wr_q   <= 1'b1;
            state     <= ST_FILL;
          end else begin
            state <= ST_NEXT_ROW;
          end
        end
        ST_FILL: begin
          if (fb_accept) begin
            if (x == span_right) begin
              fb_wr_q <= 1'b0;
              state   <= ST_NEXT_ROW;
            end else begin
              x         <= x + 1'b1;
              fb_addr_q <= fb_addr_q + 1'b1;
              wf_addr_q <= wf_addr_q + 1'b1;
            end
          end
        end
        ST_NEXT_ROW: begin
          if (y == y_max_q) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end else begin
            y         <= y + 1'b1;
            x         <= x_min_q;
            wf_addr_q <= pix_addr(y + 1'b1, x_min_q);
            state     <= ST_SCAN;
          end
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.wf_addr  = wf_addr_q;
  assign bus.wf_wdata = 1'b0;
  assign bus.fb_addr  = fb_addr_q;
  assign bus.fb_data  = fb_data_q;
  assign bus.fb_wr    = fb_wr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

`ifdef CLEAR_WF_EN
  assign bus.wf_we = fb_accept;
`else
  assign bus.wf_we = 1'b0;
`endif

endmodule

// File: tb/tb_color_fill.sv
// Directed bench for color_fill with a frame-buffer write scoreboard and a
// behavioural wireframe SRAM (1-cycle read latency).
module tb_color_fill;
  import color_fill_pkg::*;

  localparam int SW = 320;
  localparam int SH = 240;

  typedef struct packed {
    logic [FB_ADDR_SIZE-1:0] addr;
    Color                    data;
  } wr_t;

  logic clk = 1'b0;
  logic n_rst;

  color_fill_if bus();

  color_fill dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic wf_mem [0:SW*SH-1];
  wr_t  exp_q[$];
  int   checks  = 0;
  int   fails   = 0;
  int   cyc_now = 0;
  int   acc_cnt = 0;

  // Wireframe SRAM model and cycle counter
  always @(posedge clk) begin
    cyc_now <= cyc_now + 1;
    bus.wf_rdata <= wf_mem[bus.wf_addr];
    if (bus.wf_we) wf_mem[bus.wf_addr] <= bus.wf_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare each accepted frame buffer write against the queue head
  always @(negedge clk) begin : mon
    wr_t e;
    if (n_rst === 1'b1) begin
      if (bus.fb_wr && bus.fb_ready) begin
        acc_cnt++;
        checks++;
        assert (exp_q.size() != 0) else begin
          fails++;
          $error("FAIL fb_extra_write: observed addr %0d expected no write", bus.fb_addr);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("fb_addr", 32'(bus.fb_addr), 32'(e.addr));
          chk("fb_data", 32'(bus.fb_data), 32'(e.data));
        end
      end
`ifdef CLEAR_WF_EN
      chk("wf_we", 32'(bus.wf_we), 32'(bus.fb_wr & bus.fb_ready));
      if (bus.wf_we) chk("wf_clear_addr", 32'(bus.wf_addr), 32'(bus.fb_addr));
`else
      chk("wf_we_tied", 32'(bus.wf_we), 32'd0);
`endif
    end
  end

  // Reference model: expected writes and cycle count of one fill with fb_ready=1
  task automatic model(input BBox b, input Color c, input bit push, output int cyc);
    int l;
    int r;
    cyc = 1;
    if (b.x_min > b.x_max || b.y_min > b.y_max || b.x_max >= SW || b.y_max >= SH) return;
    for (int yy = int'(b.y_min); yy <= int'(b.y_max); yy++) begin
      l = -1;
      r = -1;
      for (int xx = int'(b.x_min); xx <= int'(b.x_max); xx++) begin
        if (wf_mem[yy*SW + xx] === 1'b1) begin
          if (l < 0) l = xx;
          r = xx;
        end
      end
      cyc += int'(b.x_max) - int'(b.x_min) + 1 + 2;
      if (l >= 0) begin
        cyc += r - l + 1;
        if (push)
          for (int xx = l; xx <= r; xx++) exp_q.push_back('{FB_ADDR_SIZE'(yy*SW + xx), c});
      end
    end
  endtask

  task automatic kick(input BBox b, input Color c, output int s_edge);
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.i_bbox  = b;
    bus.i_color = c;
    s_edge = cyc_now + 1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int s_edge, input int exp_cyc);
    for (int i = 0; i < 4000; i++) begin
      if (bus.done === 1'b1) break;
      @(posedge clk); #1;
    end
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_latency"}, 32'(cyc_now - s_edge + 1), 32'(exp_cyc));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    BBox  b;
    Color c;
    int   ec;
    int   se;
    int   a0;
    logic [FB_ADDR_SIZE-1:0] ha;
    Color hd;

    for (int i = 0; i < SW*SH; i++) wf_mem[i] = 1'b0;
    n_rst        = 1'b0;
    bus.start    = 1'b0;
    bus.i_bbox   = '0;
    bus.i_color  = '0;
    bus.fb_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_fb_wr", 32'(bus.fb_wr), 0);
    chk("rst_fb_addr", 32'(bus.fb_addr), 0);
    chk("rst_wf_addr", 32'(bus.wf_addr), 0);
    n_rst = 1'b1;

    // 1: three-pixel span on row 5
    wf_mem[5*SW + 10] = 1'b1;
    wf_mem[5*SW + 12] = 1'b1;
    c = 16'hABCD;
    exp_q.push_back('{17'd1610, c});
    exp_q.push_back('{17'd1611, c});
    exp_q.push_back('{17'd1612, c});
    b = '{x_min: 9'd10, x_max: 9'd12, y_min: 8'd5, y_max: 8'd5};
    kick(b, c, se);
    wait_done("t1", se, 9);

    // 2: three rows, middle row empty
    wf_mem[0*SW + 1] = 1'b1;
    wf_mem[0*SW + 3] = 1'b1;
    wf_mem[2*SW + 0] = 1'b1;
    wf_mem[2*SW + 2] = 1'b1;
    c = 16'h1234;
    b = '{x_min: 9'd0, x_max: 9'd3, y_min: 8'd0, y_max: 8'd2};
    model(b, c, 1'b1, ec);
    kick(b, c, se);
    wait_done("t2", se, 25);

    // 3: single-pixel triangle
    wf_mem[2247] = 1'b1;
    c = 16'h0F0F;
    exp_q.push_back('{17'd2247, c});
    b = '{x_min: 9'd7, x_max: 9'd7, y_min: 8'd7, y_max: 8'd7};
    kick(b, c, se);
    wait_done("t3", se, 5);
`ifdef CLEAR_WF_EN
    chk("t3_wf_cleared", 32'(wf_mem[2247]), 0);
`else
    chk("t3_wf_kept", 32'(wf_mem[2247]), 1);
`endif

    // 4: frame buffer back-pressure for 3 cycles mid-span
    wf_mem[10*SW + 21] = 1'b1;
    wf_mem[10*SW + 28] = 1'b1;
    c = 16'h5A5A;
    b = '{x_min: 9'd20, x_max: 9'd30, y_min: 8'd10, y_max: 8'd10};
    model(b, c, 1'b1, ec);
    a0 = acc_cnt;
    kick(b, c, se);
    for (int i = 0; i < 100; i++) begin
      if (acc_cnt - a0 >= 2) break;
      @(posedge clk); #1;
    end
    bus.fb_ready = 1'b0;
    @(negedge clk);
    ha = bus.fb_addr;
    hd = bus.fb_data;
    chk("t4_stall_addr", 32'(ha), 32'(10*SW + 23));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t4_hold_wr", 32'(bus.fb_wr), 1);
      chk("t4_hold_addr", 32'(bus.fb_addr), 32'(ha));
      chk("t4_hold_data", 32'(bus.fb_data), 32'(hd));
    end
    @(posedge clk); #1;
    bus.fb_ready = 1'b1;
    wait_done("t4", se, ec + 3);

    // 5: rejected boxes finish immediately; start while busy is ignored
    c = 16'h7777;
    b = '{x_min: 9'd20, x_max: 9'd10, y_min: 8'd0, y_max: 8'd0};
    kick(b, c, se);
    wait_done("t5_xinv", se, 1);
    b = '{x_min: 9'd0, x_max: 9'd320, y_min: 8'd0, y_max: 8'd0};
    kick(b, c, se);
    wait_done("t5_xoor", se, 1);
    b = '{x_min: 9'd0, x_max: 9'd5, y_min: 8'd0, y_max: 8'd240};
    kick(b, c, se);
    wait_done("t5_yoor", se, 1);
    wf_mem[20*SW + 41] = 1'b1;
    wf_mem[20*SW + 43] = 1'b1;
    wf_mem[21*SW + 40] = 1'b1;
    wf_mem[21*SW + 44] = 1'b1;
    b = '{x_min: 9'd40, x_max: 9'd44, y_min: 8'd20, y_max: 8'd21};
    model(b, c, 1'b1, ec);
    kick(b, c, se);
    repeat (3) @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.i_bbox = '{x_min: 9'd0, x_max: 9'd319, y_min: 8'd0, y_max: 8'd239};
    bus.i_color = 16'h1111;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done("t5_busy", se, ec);

    // 7: bottom-right corner, highest address
    wf_mem[238*SW + 318] = 1'b1;
    wf_mem[239*SW + 319] = 1'b1;
    c = 16'hFFFF;
    exp_q.push_back('{17'd76478, c});
    exp_q.push_back('{17'd76799, c});
    b = '{x_min: 9'd318, x_max: 9'd319, y_min: 8'd238, y_max: 8'd239};
    kick(b, c, se);
    wait_done("t7", se, 11);

    // 6: reset in the middle of a fill, then a clean rerun
    wf_mem[30*SW + 50] = 1'b1;
    wf_mem[30*SW + 60] = 1'b1;
    c = 16'h3C3C;
    b = '{x_min: 9'd50, x_max: 9'd60, y_min: 8'd30, y_max: 8'd30};
    model(b, c, 1'b1, ec);
    a0 = acc_cnt;
    kick(b, c, se);
    for (int i = 0; i < 100; i++) begin
      if (acc_cnt - a0 >= 3) break;
      @(posedge clk); #1;
    end
    chk("t6_in_fill", 32'(bus.fb_wr), 1);
    n_rst = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_busy", 32'(bus.busy), 0);
    chk("t6_rst_fb_wr", 32'(bus.fb_wr), 0);
    chk("t6_rst_fb_addr", 32'(bus.fb_addr), 0);
    chk("t6_rst_fb_data", 32'(bus.fb_data), 0);
    chk("t6_rst_wf_addr", 32'(bus.wf_addr), 0);
    chk("t6_rst_wf_we", 32'(bus.wf_we), 0);
    chk("t6_rst_done", 32'(bus.done), 0);
    n_rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    model(b, c, 1'b1, ec);
    kick(b, c, se);
    wait_done("t6_rerun", se, ec);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
